// File: rtl/pc_flush_ctrl_pkg.sv
// rtl/pc_flush_ctrl_pkg.sv - shared fetch/flush constants and depth check
package pc_flush_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_STEP       = 32'd4;
  localparam int          FLUSH_DEPTH_MIN  = 1;
  localparam int          FLUSH_DEPTH_MAX  = 3;

  function automatic bit flush_depth_legal(input int depth);
    return (depth >= FLUSH_DEPTH_MIN) && (depth <= FLUSH_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pc_delay_line.sv
// rtl/pc_delay_line.sv - enabled shift register carrying fetch addresses to execute
module pc_delay_line #(
  parameter int          DEPTH     = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL[WIDTH-1:0];
      end
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/pc_flush_ctrl.sv
// rtl/pc_flush_ctrl.sv - fetch PC sequencer with jump/mret/irq redirect and wrong-path kill
module pc_flush_ctrl
  import pc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          FLUSH_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        JREQ,
  input  logic [31:0] JVAL,
  input  logic        MRET,
  input  logic        IRQ,
  input  logic        IEN,
  input  logic [31:0] IVEC,
  output logic [31:0] IADDR,
  output logic [31:0] PC,
  output logic        KILL,
  output logic        IACK,
  output logic [31:0] EPC,
  output logic        IHND
);

  localparam int FW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_DEPTH);

  generate
    if (!flush_depth_legal(FLUSH_DEPTH)) begin : g_bad_depth
      $error("pc_flush_ctrl: FLUSH_DEPTH out of range");
    end
  endgenerate

  logic [FW-1:0] flush;
  logic          adv;
  logic          run;
  logic          irq_take;
  logic          redirect;
  logic [31:0]   target;

  assign adv      = !HLT;
  assign run      = (flush == '0);
  assign KILL     = !run;
  // Interrupts yield to any explicit redirect presented in the same cycle.
  assign irq_take = IRQ && IEN && !IHND && !JREQ && !MRET;
  assign redirect = adv && run && (JREQ || MRET || irq_take);
  assign IACK     = adv && run && irq_take;

  always_comb begin
    target = IVEC;
    if (JREQ) begin
      target = JVAL;
    end else if (MRET) begin
      target = EPC;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      IADDR <= RESET_PC;
      flush <= FLUSH_INIT;
      EPC   <= 32'h0;
      IHND  <= 1'b0;
    end else if (adv) begin
      if (redirect) begin
        IADDR <= target;
        flush <= FLUSH_INIT;
      end else begin
        IADDR <= IADDR + INSTR_STEP;
        flush <= run ? flush : flush - FW'(1);
      end
      if (run && !JREQ && MRET) begin
        IHND <= 1'b0;
      end
      if (IACK) begin
        EPC  <= PC + INSTR_STEP;
        IHND <= 1'b1;
      end
    end
  end

  pc_delay_line #(
    .DEPTH     (FLUSH_DEPTH),
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_delay (
    .clk (CLK),
    .rst (RES),
    .en  (adv),
    .d   (IADDR),
    .q   (PC)
  );

endmodule

// File: tb/tb_pc_flush_ctrl.sv
// tb/tb_pc_flush_ctrl.sv - directed self-checking bench for pc_flush_ctrl
module tb_pc_flush_ctrl;

  logic        CLK = 1'b0;
  logic        RES, HLT, JREQ, MRET, IRQ, IEN;
  logic [31:0] JVAL, IVEC;
  logic [31:0] IADDR, PC, EPC;
  logic        KILL, IACK, IHND;

  int checks = 0;
  int failures = 0;

  pc_flush_ctrl #(.RESET_PC(32'h0), .FLUSH_DEPTH(2)) dut (
    .CLK(CLK), .RES(RES), .HLT(HLT), .JREQ(JREQ), .JVAL(JVAL), .MRET(MRET),
    .IRQ(IRQ), .IEN(IEN), .IVEC(IVEC), .IADDR(IADDR), .PC(PC), .KILL(KILL),
    .IACK(IACK), .EPC(EPC), .IHND(IHND)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1; HLT = 1'b0; JREQ = 1'b0; MRET = 1'b0; IRQ = 1'b0; IEN = 1'b0;
    JVAL = 32'h0; IVEC = 32'h0;
    tick();
    RES = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RES = 1'b1;
    #1;
    checks++; if (IADDR !== 32'h0) begin failures++; $display("FAIL reset_iaddr got=%h exp=%h", IADDR, 32'h0); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    checks++; if (KILL !== 1'b1) begin failures++; $display("FAIL reset_kill got=%b exp=1", KILL); end
    checks++; if ({IACK, IHND} !== 2'b00) begin failures++; $display("FAIL reset_iack_ihnd got=%b exp=00", {IACK, IHND}); end
    checks++; if (EPC !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", EPC, 32'h0); end
    RES = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h0, 32'h0, 32'h4};
    logic        exp_kill [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      checks++; if (IADDR !== 32'(4 * c)) begin failures++; $display("FAIL seq_iaddr c=%0d got=%h exp=%h", c, IADDR, 32'(4 * c)); end
      checks++; if (KILL !== exp_kill[c]) begin failures++; $display("FAIL seq_kill c=%0d got=%b exp=%b", c, KILL, exp_kill[c]); end
      checks++; if (PC !== exp_pc[c]) begin failures++; $display("FAIL seq_pc c=%0d got=%h exp=%h", c, PC, exp_pc[c]); end
      tick();
    end
  endtask

  task automatic test_jump_and_killed_jreq();
    logic [31:0] exp_ia [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp_pc [3] = '{32'h14, 32'h18, 32'h100};
    logic        exp_kill [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    repeat (6) tick();
    checks++; if (PC !== 32'h10 || KILL !== 1'b0) begin failures++; $display("FAIL jmp_pre pc=%h kill=%b exp pc=10 kill=0", PC, KILL); end
    JREQ = 1'b1; JVAL = 32'h100;
    tick();
    JVAL = 32'h300;
    for (int c = 0; c < 3; c++) begin
      checks++; if (IADDR !== exp_ia[c]) begin failures++; $display("FAIL jmp_iaddr c=%0d got=%h exp=%h", c, IADDR, exp_ia[c]); end
      checks++; if (PC !== exp_pc[c]) begin failures++; $display("FAIL jmp_pc c=%0d got=%h exp=%h", c, PC, exp_pc[c]); end
      checks++; if (KILL !== exp_kill[c]) begin failures++; $display("FAIL jmp_kill c=%0d got=%b exp=%b", c, KILL, exp_kill[c]); end
      if (c == 1) JREQ = 1'b0;
      tick();
    end
  endtask

  task automatic test_irq_mret();
    do_reset();
    repeat (10) tick();
    IRQ = 1'b1; IEN = 1'b1; IVEC = 32'h800;
    #1;
    checks++; if (IACK !== 1'b1 || PC !== 32'h20) begin failures++; $display("FAIL irq_take iack=%b pc=%h exp iack=1 pc=20", IACK, PC); end
    tick();
    checks++; if (IADDR !== 32'h800) begin failures++; $display("FAIL irq_iaddr got=%h exp=%h", IADDR, 32'h800); end
    checks++; if (EPC !== 32'h24) begin failures++; $display("FAIL irq_epc got=%h exp=%h", EPC, 32'h24); end
    checks++; if (IHND !== 1'b1) begin failures++; $display("FAIL irq_ihnd got=%b exp=1", IHND); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (IACK !== 1'b0) begin failures++; $display("FAIL irq_no_nest c=%0d got=%b exp=0", c, IACK); end
      if (c < 2) tick();
    end
    MRET = 1'b1;
    #1;
    checks++; if (IACK !== 1'b0) begin failures++; $display("FAIL mret_iack got=%b exp=0", IACK); end
    tick();
    MRET = 1'b0;
    checks++; if (IADDR !== 32'h24 || IHND !== 1'b0) begin failures++; $display("FAIL mret_ret iaddr=%h ihnd=%b exp 24/0", IADDR, IHND); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (IACK !== 1'b0 || KILL !== 1'b1) begin failures++; $display("FAIL mret_flush c=%0d iack=%b kill=%b exp 0/1", c, IACK, KILL); end
      tick();
    end
    checks++; if (IACK !== 1'b1 || IADDR !== 32'h2c) begin failures++; $display("FAIL irq_retake iack=%b iaddr=%h exp 1/2c", IACK, IADDR); end
    tick();
    IRQ = 1'b0;
    checks++; if (IADDR !== 32'h800 || EPC !== 32'h28) begin failures++; $display("FAIL irq_retake2 iaddr=%h epc=%h exp 800/28", IADDR, EPC); end
  endtask

  task automatic test_irq_vs_jump();
    do_reset();
    repeat (4) tick();
    IRQ = 1'b1; IEN = 1'b1; IVEC = 32'h800; JREQ = 1'b1; JVAL = 32'h200;
    #1;
    checks++; if (IACK !== 1'b0) begin failures++; $display("FAIL irqjmp_iack got=%b exp=0", IACK); end
    tick();
    JREQ = 1'b0;
    checks++; if (IADDR !== 32'h200 || IHND !== 1'b0) begin failures++; $display("FAIL irqjmp_target iaddr=%h ihnd=%b exp 200/0", IADDR, IHND); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (IACK !== 1'b0) begin failures++; $display("FAIL irqjmp_flush c=%0d got=%b exp=0", c, IACK); end
      tick();
    end
    checks++; if (IACK !== 1'b1 || PC !== 32'h200) begin failures++; $display("FAIL irqjmp_late iack=%b pc=%h exp 1/200", IACK, PC); end
    tick();
    IRQ = 1'b0;
    checks++; if (IADDR !== 32'h800 || EPC !== 32'h204) begin failures++; $display("FAIL irqjmp_vec iaddr=%h epc=%h exp 800/204", IADDR, EPC); end
  endtask

  task automatic test_halt_and_reset();
    do_reset();
    repeat (4) tick();
    HLT = 1'b1; JREQ = 1'b1; JVAL = 32'h300; IRQ = 1'b1; IEN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (IADDR !== 32'h10 || PC !== 32'h8) begin failures++; $display("FAIL halt_frozen c=%0d iaddr=%h pc=%h exp 10/8", c, IADDR, PC); end
      checks++; if (KILL !== 1'b0 || IACK !== 1'b0 || dut.flush !== 2'd0) begin failures++; $display("FAIL halt_ctl c=%0d kill=%b iack=%b flush=%0d exp 0/0/0", c, KILL, IACK, dut.flush); end
    end
    HLT = 1'b0;
    tick();
    JREQ = 1'b0; IRQ = 1'b0;
    checks++; if (IADDR !== 32'h300 || dut.flush !== 2'd2) begin failures++; $display("FAIL halt_release iaddr=%h flush=%0d exp 300/2", IADDR, dut.flush); end
    tick();
    #2;
    RES = 1'b1;
    #1;
    checks++; if (IADDR !== 32'h0 || PC !== 32'h0 || dut.flush !== 2'd2 || KILL !== 1'b1) begin failures++; $display("FAIL midflush_reset iaddr=%h pc=%h flush=%0d kill=%b exp 0/0/2/1", IADDR, PC, dut.flush, KILL); end
    RES = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_and_killed_jreq();
    test_irq_mret();
    test_irq_vs_jump();
    test_halt_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_flush_ctrl.md
Name: pc_flush_ctrl

Overview:
Fetch-address sequencer and pipeline-flush controller for the core.
- Owns the fetch PC (IADDR) and a delay line that tracks the PC of the instruction currently in execute.
- Accepts redirects from the branch unit (JREQ/JVAL), MRET and a level interrupt, and kills the wrong-path instructions already in flight.
- Sits between the branch unit outputs and the instruction-fetch/execute stages.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset.
FLUSH_DEPTH, 2, number of pipeline stages between fetch and execute; legal range 1..3.

Ports:
CLK  input  1  core clock.
RES  input  1  asynchronous, active-high reset.
HLT  input  1  stall; freezes all state while high.
JREQ  input  1  jump/taken-branch request from the branch unit.
JVAL  input  32  jump target from the branch unit.
MRET  input  1  return-from-interrupt request from execute.
IRQ  input  1  level interrupt request; held high by the requester until IACK.
IEN  input  1  global interrupt enable.
IVEC  input  32  interrupt handler address.
IADDR  output  32  fetch address.
PC  output  32  address of the instruction in execute.
KILL  output  1  instruction in execute is wrong-path; suppress all its side effects.
IACK  output  1  one-cycle pulse when the interrupt is taken.
EPC  output  32  saved return address.
IHND  output  1  in-handler flag.

Behaviour:
Reset (async, RES=1):
- IADDR=RESET_PC; every delay-line entry=RESET_PC; PC=RESET_PC.
- FLUSH counter=FLUSH_DEPTH, so KILL=1.
- EPC=0, IHND=0, IACK=0.

Definitions:
- adv = !HLT.
- run = (FLUSH==0).
- FLUSH width is clog2(FLUSH_DEPTH+1).

Delay line:
- FLUSH_DEPTH registers. On each adv cycle, entry0<=IADDR and entry[i]<=entry[i-1].
- PC = last entry, so PC equals IADDR delayed by FLUSH_DEPTH advance cycles.

Redirect select (combinational, priority order, only when adv && run):
1. JREQ -> target JVAL. If JREQ and MRET are both high, JREQ wins; this case is illegal but defined.
2. MRET -> target EPC; IHND<=0 on that edge.
3. irq_take = IRQ && IEN && !IHND && !JREQ && !MRET -> target IVEC; EPC<=PC+4 (mod 2^32); IHND<=1; IACK=1 during the take cycle (combinational, registered-safe).

Update on an adv cycle:
- With redirect: IADDR<=target, FLUSH<=FLUSH_DEPTH.
- Without redirect: IADDR<=IADDR+4 (wraps mod 2^32), FLUSH<=FLUSH-1, saturating at 0.

Other rules:
- KILL = (FLUSH!=0), combinational. Instructions fetched before a redirect execute killed for exactly FLUSH_DEPTH adv cycles; the target reaches PC on the (FLUSH_DEPTH+1)th adv cycle after the request edge.
- During flush (!run), JREQ, MRET and IRQ are ignored; they come from killed instructions. A pending IRQ is simply taken later, because it is level.
- HLT=1: no register changes, IACK=0, redirect requests are not consumed. The branch unit re-presents them after the stall.
- JVAL/IVEC/EPC are used verbatim; no alignment masking.
- Nested interrupts are blocked by IHND until MRET.
- RES asserted mid-flush or mid-handler returns immediately to the reset values; a pending redirect is discarded.

Decomposition:
- Shared core package: reset-PC constant, instruction step constant (4) and the FLUSH_DEPTH legal-range check.
- One natural sub-module: pc_delay_line (parameterised depth shift register with enable and async reset), instantiated once.
- Redirect priority and the FLUSH counter stay in pc_flush_ctrl.

Test Plan:
(All scenarios use FLUSH_DEPTH=2, RESET_PC=0.)
1. Release RES, HLT=0 -> IADDR 0,4,8,12 on successive cycles. KILL=1 for the first 2 cycles; PC=0 with KILL=0 on cycle 2, PC=4 on cycle 3.
2. At PC=0x10 in run, pulse JREQ with JVAL=0x100 -> next cycle IADDR=0x100. KILL=1 for 2 cycles with PC=0x14 then 0x18. Then PC=0x100 with KILL=0.
3. JREQ asserted on both killed cycles of scenario 2 -> ignored; IADDR continues 0x104, 0x108.
4. IRQ=1, IEN=1 at PC=0x20, IVEC=0x800 -> IACK pulses once, EPC=0x24, IHND=1, IADDR=0x800. IRQ held high afterwards -> no second IACK. MRET in the handler -> IADDR=0x24, IHND=0, and a held IRQ is re-taken after the 2 flush cycles.
5. IRQ and JREQ (JVAL=0x200) in the same cycle -> jump taken, no IACK. IRQ is taken in the first run cycle after the flush.
6. HLT=1 for 3 cycles with JREQ held -> IADDR, PC and FLUSH frozen, IACK=0. On HLT=0 the jump is taken. RES pulsed during the flush -> IADDR=0, FLUSH=2.
